// File: rtl/i2s_codec_bridge_if.sv
// rtl/i2s_codec_bridge_if.sv - recorder-side sample streams of the I2S codec bridge
interface i2s_codec_bridge_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] adc_left_data;
  logic              adc_left_valid;
  logic              adc_left_ready;
  logic [DATA_W-1:0] adc_right_data;
  logic              adc_right_valid;
  logic              adc_right_ready;
  logic [DATA_W-1:0] dac_left_data;
  logic              dac_left_valid;
  logic              dac_left_ready;
  logic [DATA_W-1:0] dac_right_data;
  logic              dac_right_valid;
  logic              dac_right_ready;

  modport master (
    output adc_left_data, adc_left_valid, adc_right_data, adc_right_valid,
    input  adc_left_ready, adc_right_ready,
    input  dac_left_data, dac_left_valid, dac_right_data, dac_right_valid,
    output dac_left_ready, dac_right_ready
  );

  modport slave (
    input  adc_left_data, adc_left_valid, adc_right_data, adc_right_valid,
    output adc_left_ready, adc_right_ready,
    output dac_left_data, dac_left_valid, dac_right_data, dac_right_valid,
    input  dac_left_ready, dac_right_ready
  );
endinterface

// File: rtl/i2s_codec_bridge.sv
// rtl/i2s_codec_bridge.sv - WM8731 I2S ADC deserializer and DAC serializer
// Codec is clock master; all codec lines are oversampled on i_clk.
module i2s_codec_bridge #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_aud_bclk,
  input  logic               i_aud_adclrck,
  input  logic               i_aud_adcdat,
  input  logic               i_aud_daclrck,
  output logic               o_aud_dacdat,
  i2s_codec_bridge_if.master st,
  input  logic               i_clr_flags,
  output logic               o_adc_overrun,
  output logic               o_dac_underrun
);
  localparam int RX_CW = $clog2(DATA_W);
  localparam int TX_CW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {RX_IDLE, RX_SKIP, RX_SHIFT, RX_LOAD, RX_WAIT} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_WAIT_FALL, TX_SHIFT} tx_state_e;

  // synchronizer lanes: {daclrck, adcdat, adclrck, bclk}
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync_d [SYNC_STAGES];
  logic [3:0] prev_q, prev_d;
  logic [3:0] cur;

  rx_state_e         rx_state_q, rx_state_d;
  logic              rx_ch_q, rx_ch_d;
  logic [RX_CW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] adc_l_data_q, adc_l_data_d, adc_r_data_q, adc_r_data_d;
  logic              adc_l_valid_q, adc_l_valid_d, adc_r_valid_q, adc_r_valid_d;
  logic              overrun_q, overrun_d;

  tx_state_e         tx_state_q, tx_state_d;
  logic [TX_CW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              dacdat_q, dacdat_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic              full_l_q, full_l_d, full_r_q, full_r_d;
  logic              underrun_q, underrun_d;

  logic bclk_rise, bclk_fall, adc_edge, dac_edge, adcdat;
  logic rx_load_l, rx_load_r, drain_l, drain_r, acc_l, acc_r;

  assign cur       = sync_q[SYNC_STAGES-1];
  assign bclk_rise = cur[0] & ~prev_q[0];
  assign bclk_fall = ~cur[0] & prev_q[0];
  assign adc_edge  = cur[1] ^ prev_q[1];
  assign dac_edge  = cur[3] ^ prev_q[3];
  // data lane one stage behind the bclk edge: settled well before the rise
  assign adcdat    = prev_q[2];

  always_comb begin
    sync_d[0] = {i_aud_daclrck, i_aud_adcdat, i_aud_adclrck, i_aud_bclk};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d = cur;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_ch_d    = rx_ch_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      RX_SKIP, RX_SHIFT: begin
        if (adc_edge) begin
          rx_ch_d    = cur[1];
          rx_state_d = RX_SKIP;
        end else if (bclk_rise && rx_state_q == RX_SKIP) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_SHIFT;
        end else if (bclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], adcdat};
          rx_cnt_d   = rx_cnt_q + RX_CW'(1);
          if (rx_cnt_q == RX_CW'(DATA_W - 1)) rx_state_d = RX_LOAD;
        end
      end
      RX_LOAD: begin
        rx_state_d = RX_WAIT;
        if (adc_edge) begin
          rx_ch_d    = cur[1];
          rx_state_d = RX_SKIP;
        end
      end
      default: begin
        if (adc_edge) begin
          rx_ch_d    = cur[1];
          rx_state_d = RX_SKIP;
        end
      end
    endcase
  end

  assign rx_load_l = (rx_state_q == RX_LOAD) && !rx_ch_q;
  assign rx_load_r = (rx_state_q == RX_LOAD) && rx_ch_q;

  always_comb begin
    adc_l_valid_d = adc_l_valid_q & ~st.adc_left_ready;
    adc_r_valid_d = adc_r_valid_q & ~st.adc_right_ready;
    adc_l_data_d  = adc_l_data_q;
    adc_r_data_d  = adc_r_data_q;
    overrun_d     = overrun_q & ~i_clr_flags;
    if (rx_load_l) begin
      adc_l_data_d  = rx_shift_q;
      adc_l_valid_d = 1'b1;
      if (adc_l_valid_q && !st.adc_left_ready) overrun_d = 1'b1;
    end
    if (rx_load_r) begin
      adc_r_data_d  = rx_shift_q;
      adc_r_valid_d = 1'b1;
      if (adc_r_valid_q && !st.adc_right_ready) overrun_d = 1'b1;
    end
  end

  // a drain frees the holding register in the same cycle, so a waiting word lands there
  assign drain_l  = dac_edge & ~cur[3];
  assign drain_r  = dac_edge & cur[3];
  assign acc_l    = st.dac_left_valid & (~full_l_q | drain_l);
  assign acc_r    = st.dac_right_valid & (~full_r_q | drain_r);
  assign hold_l_d = acc_l ? st.dac_left_data : hold_l_q;
  assign hold_r_d = acc_r ? st.dac_right_data : hold_r_q;
  assign full_l_d = acc_l | (full_l_q & ~drain_l);
  assign full_r_d = acc_r | (full_r_q & ~drain_r);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    dacdat_d   = dacdat_q;
    underrun_d = underrun_q & ~i_clr_flags;
    if (dac_edge) begin
      tx_state_d = TX_WAIT_FALL;
      tx_cnt_d   = '0;
      dacdat_d   = 1'b0;
      if (cur[3] ? full_r_q : full_l_q) begin
        tx_shift_d = cur[3] ? hold_r_q : hold_l_q;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end else if (tx_state_q != TX_IDLE && bclk_fall) begin
      if (tx_cnt_q < TX_CW'(DATA_W)) begin
        dacdat_d   = tx_shift_q[DATA_W-1];
        tx_shift_d = tx_shift_q << 1;
        tx_cnt_d   = tx_cnt_q + TX_CW'(1);
        tx_state_d = TX_SHIFT;
      end else begin
        dacdat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q        <= '0;
      rx_state_q    <= RX_IDLE;
      rx_ch_q       <= 1'b0;
      rx_cnt_q      <= '0;
      rx_shift_q    <= '0;
      adc_l_data_q  <= '0;
      adc_r_data_q  <= '0;
      adc_l_valid_q <= 1'b0;
      adc_r_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      tx_state_q    <= TX_IDLE;
      tx_cnt_q      <= '0;
      tx_shift_q    <= '0;
      dacdat_q      <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      full_l_q      <= 1'b0;
      full_r_q      <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      prev_q        <= prev_d;
      rx_state_q    <= rx_state_d;
      rx_ch_q       <= rx_ch_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_shift_q    <= rx_shift_d;
      adc_l_data_q  <= adc_l_data_d;
      adc_r_data_q  <= adc_r_data_d;
      adc_l_valid_q <= adc_l_valid_d;
      adc_r_valid_q <= adc_r_valid_d;
      overrun_q     <= overrun_d;
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_shift_q    <= tx_shift_d;
      dacdat_q      <= dacdat_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      full_l_q      <= full_l_d;
      full_r_q      <= full_r_d;
      underrun_q    <= underrun_d;
    end
  end

  assign st.adc_left_data   = adc_l_data_q;
  assign st.adc_left_valid  = adc_l_valid_q;
  assign st.adc_right_data  = adc_r_data_q;
  assign st.adc_right_valid = adc_r_valid_q;
  assign st.dac_left_ready  = ~full_l_q;
  assign st.dac_right_ready = ~full_r_q;
  assign o_aud_dacdat       = dacdat_q;
  assign o_adc_overrun      = overrun_q;
  assign o_dac_underrun     = underrun_q;
endmodule

// File: tb/tb_i2s_codec_bridge.sv
// tb/tb_i2s_codec_bridge.sv - directed scoreboard bench for i2s_codec_bridge
`timescale 1ns/1ps
module tb_i2s_codec_bridge;
  localparam int DW    = 16;
  localparam int SS    = 2;
  localparam int HALF  = 8;
  localparam int SLOTS = 18;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bclk = 1'b1, adclrck = 1'b1, adcdat = 1'b0, daclrck = 1'b1, clr = 1'b0;
  logic dacdat, ovr, und;

  exp_t          exp_l[$], exp_r[$], mon_e;
  logic [DW-1:0] exp_dac[$];
  int total = 0, bad = 0, cyc = 0;

  i2s_codec_bridge_if #(.DATA_W(DW)) aud_if ();

  i2s_codec_bridge #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_aud_bclk(bclk), .i_aud_adclrck(adclrck), .i_aud_adcdat(adcdat),
    .i_aud_daclrck(daclrck), .o_aud_dacdat(dacdat),
    .st(aud_if.master),
    .i_clr_flags(clr), .o_adc_overrun(ovr), .o_dac_underrun(und)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // an unconsumed sample is overwritten in place by the next one
  task automatic push_adc(input logic lr, input logic [DW-1:0] w);
    exp_t e;
    e.data = w;
    if (!lr) begin
      e.due = aud_if.adc_left_ready ? cyc + SS + 2 : -1;
      if (!aud_if.adc_left_ready && exp_l.size() > 0) void'(exp_l.pop_back());
      exp_l.push_back(e);
    end else begin
      e.due = aud_if.adc_right_ready ? cyc + SS + 2 : -1;
      if (!aud_if.adc_right_ready && exp_r.size() > 0) void'(exp_r.pop_back());
      exp_r.push_back(e);
    end
  endtask

  task automatic half_frame(input logic lr, input logic [DW-1:0] adc_w,
                            input bit do_adc, input bit do_dac, input int slots);
    logic [DW-1:0] got = '0;
    logic [DW-1:0] exp_w;
    for (int k = 0; k < slots; k++) begin
      bclk = 1'b0;
      if (k == 0) begin
        if (do_adc) adclrck = lr;
        if (do_dac) daclrck = lr;
      end
      adcdat = (k >= 1 && k <= DW) ? adc_w[DW-k] : 1'b0;
      tick(HALF);
      bclk = 1'b1;
      if (k >= 1 && k <= DW) got[DW-k] = dacdat;
      if (k == DW && do_adc) push_adc(lr, adc_w);
      tick(HALF);
    end
    if (do_dac && slots > DW) begin
      exp_w = 'x;
      if (exp_dac.size() > 0) exp_w = exp_dac.pop_front();
      chk(lr ? "dac_word_r" : "dac_word_l", 32'(got), 32'(exp_w));
    end
  endtask

  task automatic load_dac(input logic lr, input logic [DW-1:0] w);
    if (!lr) begin
      aud_if.dac_left_data = w; aud_if.dac_left_valid = 1'b1;
    end else begin
      aud_if.dac_right_data = w; aud_if.dac_right_valid = 1'b1;
    end
    tick(1);
    aud_if.dac_left_valid  = 1'b0;
    aud_if.dac_right_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (aud_if.adc_left_valid && aud_if.adc_left_ready) begin
        if (exp_l.size() > 0) begin
          mon_e = exp_l.pop_front();
          chk("adc_l_data", 32'(aud_if.adc_left_data), 32'(mon_e.data));
          if (mon_e.due >= 0) chk("adc_l_latency", cyc, mon_e.due);
        end else chk("adc_l_spurious", 32'(aud_if.adc_left_valid), 0);
      end
      if (aud_if.adc_right_valid && aud_if.adc_right_ready) begin
        if (exp_r.size() > 0) begin
          mon_e = exp_r.pop_front();
          chk("adc_r_data", 32'(aud_if.adc_right_data), 32'(mon_e.data));
          if (mon_e.due >= 0) chk("adc_r_latency", cyc, mon_e.due);
        end else chk("adc_r_spurious", 32'(aud_if.adc_right_valid), 0);
      end
    end
  end

  initial begin
    aud_if.adc_left_ready  = 1'b1;
    aud_if.adc_right_ready = 1'b1;
    aud_if.dac_left_data   = '0;
    aud_if.dac_left_valid  = 1'b0;
    aud_if.dac_right_data  = '0;
    aud_if.dac_right_valid = 1'b0;

    tick(3);
    chk("rst_dacdat", 32'(dacdat), 0);
    chk("rst_valid_l", 32'(aud_if.adc_left_valid), 0);
    chk("rst_valid_r", 32'(aud_if.adc_right_valid), 0);
    chk("rst_data_l", 32'(aud_if.adc_left_data), 0);
    chk("rst_data_r", 32'(aud_if.adc_right_data), 0);
    chk("rst_ready_l", 32'(aud_if.dac_left_ready), 1);
    chk("rst_ready_r", 32'(aud_if.dac_right_ready), 1);
    chk("rst_overrun", 32'(ovr), 0);
    chk("rst_underrun", 32'(und), 0);
    rst = 1'b0;
    tick(10);
    pulse_clr();

    // ADC capture, consumer always ready
    half_frame(1'b0, 16'hA5C3, 1'b1, 1'b0, SLOTS);
    half_frame(1'b1, 16'h1234, 1'b1, 1'b0, SLOTS);
    chk("cap_no_overrun", 32'(ovr), 0);
    chk("cap_drained_l", exp_l.size(), 0);
    chk("cap_drained_r", exp_r.size(), 0);

    // ADC overrun on left
    aud_if.adc_left_ready = 1'b0;
    half_frame(1'b0, 16'h1111, 1'b1, 1'b0, SLOTS);
    chk("ovr_first_data", 32'(aud_if.adc_left_data), 32'h1111);
    chk("ovr_first_flag", 32'(ovr), 0);
    half_frame(1'b1, 16'hABCD, 1'b1, 1'b0, SLOTS);
    half_frame(1'b0, 16'h2222, 1'b1, 1'b0, SLOTS);
    chk("ovr_data", 32'(aud_if.adc_left_data), 32'h2222);
    chk("ovr_valid", 32'(aud_if.adc_left_valid), 1);
    chk("ovr_flag", 32'(ovr), 1);
    aud_if.adc_left_ready = 1'b1;
    tick(2);
    chk("ovr_valid_cleared", 32'(aud_if.adc_left_valid), 0);
    pulse_clr();
    chk("ovr_flag_cleared", 32'(ovr), 0);

    // DAC playback
    load_dac(1'b0, 16'h8001);
    chk("play_ready_l_full", 32'(aud_if.dac_left_ready), 0);
    load_dac(1'b1, 16'h7FFE);
    chk("play_ready_r_full", 32'(aud_if.dac_right_ready), 0);
    exp_dac.push_back(16'h8001);
    exp_dac.push_back(16'h7FFE);
    half_frame(1'b0, '0, 1'b0, 1'b1, SLOTS);
    chk("play_ready_l_back", 32'(aud_if.dac_left_ready), 1);
    half_frame(1'b1, '0, 1'b0, 1'b1, SLOTS);
    chk("play_ready_r_back", 32'(aud_if.dac_right_ready), 1);
    chk("play_no_underrun", 32'(und), 0);

    // DAC underrun
    exp_dac.push_back('0);
    half_frame(1'b0, '0, 1'b0, 1'b1, SLOTS);
    chk("und_flag", 32'(und), 1);
    pulse_clr();
    chk("und_flag_cleared", 32'(und), 0);

    // accept and drain in the same cycle on a full left register
    load_dac(1'b0, 16'h0F0F);
    aud_if.dac_left_data  = 16'hF0F0;
    aud_if.dac_left_valid = 1'b1;
    exp_dac.push_back('0);
    half_frame(1'b1, '0, 1'b0, 1'b1, SLOTS);
    exp_dac.push_back(16'h0F0F);
    half_frame(1'b0, '0, 1'b0, 1'b1, SLOTS);
    aud_if.dac_left_valid = 1'b0;
    chk("same_cycle_ready", 32'(aud_if.dac_left_ready), 0);
    exp_dac.push_back('0);
    half_frame(1'b1, '0, 1'b0, 1'b1, SLOTS);
    exp_dac.push_back(16'hF0F0);
    half_frame(1'b0, '0, 1'b0, 1'b1, SLOTS);
    pulse_clr();

    // asynchronous reset in the middle of a word
    aud_if.adc_right_ready = 1'b0;
    load_dac(1'b0, 16'hFFFF);
    exp_dac.push_back('0);
    half_frame(1'b1, 16'h5A5A, 1'b1, 1'b1, SLOTS);
    half_frame(1'b0, 16'h3C3C, 1'b1, 1'b1, 8);
    chk("pre_rst_dacdat", 32'(dacdat), 1);
    chk("pre_rst_valid_r", 32'(aud_if.adc_right_valid), 1);
    #7 rst = 1'b1;
    #1;
    chk("mid_rst_dacdat", 32'(dacdat), 0);
    chk("mid_rst_valid_l", 32'(aud_if.adc_left_valid), 0);
    chk("mid_rst_valid_r", 32'(aud_if.adc_right_valid), 0);
    exp_l.delete();
    exp_r.delete();
    tick(2);
    aud_if.adc_right_ready = 1'b1;
    rst = 1'b0;
    tick(4);
    chk("post_rst_ready_l", 32'(aud_if.dac_left_ready), 1);
    half_frame(1'b1, 16'hBEEF, 1'b1, 1'b0, SLOTS);
    half_frame(1'b0, 16'hC0DE, 1'b1, 1'b0, SLOTS);
    tick(4);
    chk("end_drained_l", exp_l.size(), 0);
    chk("end_drained_r", exp_r.size(), 0);
    chk("end_dac_drained", exp_dac.size(), 0);
    chk("end_overrun", 32'(ovr), 0);
    chk("end_underrun", 32'(und), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
